regfile4_rd2: RTL and testbench
===============================

Name: regfile4_rd2

Overview:
- 4-entry x WIDTH-bit register bank that sits directly upstream of the 4:1 select stage.
- Holds four operands.
- Presents two independently selected read ports.
- Each read port is a 4:1 selection over the four registers, addressed by a 2-bit select.
- Used as the operand source feeding the datapath muxes in the structural CPU.

Parameters:
- WIDTH, 16, data width of each register and of all data ports.
- BYPASS, 1, 1 = a write is visible on a read port in the same cycle (write-through); 0 = visible only after the clock edge.
- RESET_VAL, 0, value loaded into every register on reset (WIDTH bits, zero-extended).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable.
- waddr  input  2  write register index 0..3.
- wdata  input  WIDTH  write data.
- raddr_a  input  2  read port A select.
- raddr_b  input  2  read port B select.
- rdata_a  output  WIDTH  read port A data.
- rdata_b  output  WIDTH  read port B data.
- valid  output  4  per-register written-since-reset flag; bit i = register i.
- wr_count  output  8  saturating count of accepted writes since reset.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled only on the rising edge of clk.
- Reset (rst=1 at the edge):
  - all four registers <= RESET_VAL; valid <= 4'b0000; wr_count <= 0.
  - rst has priority over we in the same cycle; that write is discarded and not counted.
- Write: at the rising edge with rst=0 and we=1:
  - reg[waddr] <= wdata;
  - valid[waddr] <= 1;
  - wr_count <= wr_count+1, saturating at 255 (stays 255 on further writes).
- we=0: registers, valid and wr_count hold.
- Writing an already-valid register overwrites it; valid stays 1; the write is counted.
- Reads are combinational, zero cycles:
  - rdata_a = reg[raddr_a]; rdata_b = reg[raddr_b].
  - Selection is a 4:1 mux per port: 00->reg0, 01->reg1, 10->reg2, 11->reg3.
- Bypass (BYPASS=1):
  - if we=1, rst=0 and raddr_x==waddr, then rdata_x = wdata in that same cycle.
  - Applies independently to each port, including both ports at once.
  - Suppressed while rst=1: the port shows the stored register.
- No bypass (BYPASS=0): rdata_x shows the old value until the edge and the new value from the next cycle.
- Both ports may select the same register: identical data, no conflict.
- Reads of a register with valid=0 return RESET_VAL; this is not an error.
- X on we is not tolerated; on-chip logic guarantees a clean we.
- Widths: no arithmetic on data. wr_count is an 8-bit unsigned saturating counter.
- Outputs after reset, with we=0: rdata_a = rdata_b = RESET_VAL, valid = 0, wr_count = 0.

Decomposition:
- Shared package:
  - REG_COUNT = 4, ADDR_W = 2, CNT_W = 8, CNT_MAX = 255.
  - a reg_idx_t typedef (2-bit) used for waddr/raddr.
- Sub-module reg_en_w: WIDTH-bit register with synchronous active-high reset to RESET_VAL and load enable. Instantiated four times; each load enable = we & (waddr==i).
- Read selection reuses the team's existing 4:1 mux cell, instantiated bitwise per port.
- Bypass compare, valid flags and counter are in the top level.

Test Plan:
- Reset: drive rst=1 for 2 cycles, then release with we=0.
  -> rdata_a = rdata_b = 0x0000, valid = 0000, wr_count = 0.
- Write and read all: write reg0=0x1111, reg1=0x2222, reg2=0x3333, reg3=0x4444 on consecutive cycles; then sweep raddr_a 0..3 with raddr_b = 3 - raddr_a.
  -> A reads 1111/2222/3333/4444, B reads 4444/3333/2222/1111; valid = 1111; wr_count = 4.
- Same-cycle bypass (BYPASS=1): reg2=0x3333; assert we=1, waddr=2, wdata=0xBEEF, raddr_a=raddr_b=2.
  -> Both ports show 0xBEEF before the edge.
  -> Same stimulus with BYPASS=0 shows 0x3333 before the edge and 0xBEEF after it.
- Reset beats write: rst=1 and we=1, waddr=1, wdata=0xAAAA in the same cycle.
  -> reg1 = 0x0000, valid[1] = 0, wr_count = 0 after the edge.
- Counter saturation: 300 consecutive writes to random addresses with random data.
  -> wr_count = 255 and holds.
  -> The last written value per address is readable on both ports.
- Random regression: 500 cycles of random we/waddr/wdata/raddr_a/raddr_b, checked every cycle against a reference model including the bypass rule.
  -> Zero mismatches.

Source files
------------

// File: rtl/regfile4_rd2_pkg.sv
// regfile4_rd2_pkg: shared sizes and index type for the 4-entry register bank
package regfile4_rd2_pkg;
  localparam int REG_COUNT = 4;
  localparam int ADDR_W = 2;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;
  typedef logic [ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/regfile4_rd2_if.sv
// regfile4_rd2_if: write/read bus of the register bank
interface regfile4_rd2_if
  import regfile4_rd2_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic we;
  reg_idx_t waddr;
  logic [WIDTH-1:0] wdata;
  reg_idx_t raddr_a;
  reg_idx_t raddr_b;
  logic [WIDTH-1:0] rdata_a;
  logic [WIDTH-1:0] rdata_b;
  logic [REG_COUNT-1:0] valid;
  logic [CNT_W-1:0] wr_count;
  modport master(output we, waddr, wdata, raddr_a, raddr_b, input rdata_a, rdata_b, valid, wr_count);
  modport slave(input we, waddr, wdata, raddr_a, raddr_b, output rdata_a, rdata_b, valid, wr_count);
endinterface

// File: rtl/regfile4_rd2_mux4.sv
// mux4: single-bit 4:1 select cell
module mux4 (
  input  logic [3:0] d_i,
  input  logic [1:0] sel_i,
  output logic       y_o
);
  assign y_o = d_i[sel_i];
endmodule

// File: rtl/regfile4_rd2_reg_en_w.sv
// reg_en_w: WIDTH-bit register with load enable and sync reset to RESET_VAL
module reg_en_w #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  // load on enable, reset wins
  always_ff @(posedge clk)
    if (rst) q_o <= RESET_VAL;
    else if (en_i) q_o <= d_i;
endmodule

// File: rtl/regfile4_rd2.sv
// regfile4_rd2: 4 x WIDTH register bank with two combinational read ports and optional write-through
module regfile4_rd2
  import regfile4_rd2_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BYPASS = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic clk,
  input logic rst,
  regfile4_rd2_if.slave bus
);
  logic [WIDTH-1:0] reg_q [REG_COUNT];
  logic [WIDTH-1:0] mux_a, mux_b;
  logic [REG_COUNT-1:0] valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  for (genvar g = 0; g < REG_COUNT; g++) begin : g_reg
    reg_en_w #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_reg (
      .clk(clk), .rst(rst), .en_i(bus.we && bus.waddr == reg_idx_t'(g)),
      .d_i(bus.wdata), .q_o(reg_q[g])
    );
  end
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    mux4 u_mux_a (.d_i({reg_q[3][b], reg_q[2][b], reg_q[1][b], reg_q[0][b]}), .sel_i(bus.raddr_a), .y_o(mux_a[b]));
    mux4 u_mux_b (.d_i({reg_q[3][b], reg_q[2][b], reg_q[1][b], reg_q[0][b]}), .sel_i(bus.raddr_b), .y_o(mux_b[b]));
  end
  // write-through only for a real (non-reset) write hitting the selected register
  assign bus.rdata_a = (BYPASS != 0 && bus.we && !rst && bus.raddr_a == bus.waddr) ? bus.wdata : mux_a;
  assign bus.rdata_b = (BYPASS != 0 && bus.we && !rst && bus.raddr_b == bus.waddr) ? bus.wdata : mux_b;
  assign bus.valid = valid_q;
  assign bus.wr_count = cnt_q;
  // mark written register and count writes, saturating
  always_comb begin
    valid_d = valid_q | (bus.we ? REG_COUNT'(1) << bus.waddr : '0);
    cnt_d = (bus.we && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
  end
  // flag and counter state, reset has priority over write
  always_ff @(posedge clk)
    if (rst) begin
      valid_q <= '0;
      cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_regfile4_rd2.sv
// tb_regfile4_rd2: checks bypass and non-bypass banks against an array model
module tb_regfile4_rd2;
  logic clk = 0;
  logic rst = 1;
  int tests = 0;
  int fails = 0;
  logic [15:0] m_reg [4];
  logic [3:0] m_valid;
  int m_cnt;
  logic c_rst, c_we;
  logic [1:0] c_wa, c_ra, c_rb;
  logic [15:0] c_wd;

  regfile4_rd2_if #(.WIDTH(16)) ifa ();
  regfile4_rd2_if #(.WIDTH(16)) ifb ();

  regfile4_rd2 #(.WIDTH(16), .BYPASS(1), .RESET_VAL(16'h0000)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  regfile4_rd2 #(.WIDTH(16), .BYPASS(0), .RESET_VAL(16'h0000)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_rd(input bit byp, input logic [1:0] ra);
    return (byp && c_we && !c_rst && ra == c_wa) ? c_wd : m_reg[ra];
  endfunction

  task automatic drive(input logic r, input logic w, input logic [1:0] wa, input logic [15:0] wd,
                       input logic [1:0] ra, input logic [1:0] rb);
    c_rst = r; c_we = w; c_wa = wa; c_wd = wd; c_ra = ra; c_rb = rb;
    rst = r;
    ifa.we = w; ifa.waddr = wa; ifa.wdata = wd; ifa.raddr_a = ra; ifa.raddr_b = rb;
    ifb.we = w; ifb.waddr = wa; ifb.wdata = wd; ifb.raddr_a = ra; ifb.raddr_b = rb;
    #1;
    check("byp_rdata_a", ifa.rdata_a, exp_rd(1, ra));
    check("byp_rdata_b", ifa.rdata_b, exp_rd(1, rb));
    check("nobyp_rdata_a", ifb.rdata_a, exp_rd(0, ra));
    check("nobyp_rdata_b", ifb.rdata_b, exp_rd(0, rb));
    check("valid", ifa.valid, m_valid);
    check("wr_count", ifa.wr_count, m_cnt);
    check("nobyp_wr_count", ifb.wr_count, m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    if (c_rst) begin
      for (int i = 0; i < 4; i++) m_reg[i] = 16'h0000;
      m_valid = 4'b0000;
      m_cnt = 0;
    end else if (c_we) begin
      m_reg[c_wa] = c_wd;
      m_valid[c_wa] = 1'b1;
      m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_reg[i] = 16'hxxxx;
    m_valid = 4'bxxxx;
    m_cnt = 'x;
    c_rst = 1; c_we = 0; c_wa = 0; c_wd = 0; c_ra = 0; c_rb = 0;
    ifa.we = 0; ifa.waddr = 0; ifa.wdata = 0; ifa.raddr_a = 0; ifa.raddr_b = 0;
    ifb.we = 0; ifb.waddr = 0; ifb.wdata = 0; ifb.raddr_a = 0; ifb.raddr_b = 0;
    rst = 1;
    tick();
    tick();
    drive(0, 0, 0, 0, 0, 1);
    check("reset_rdata_a", ifa.rdata_a, 16'h0000);
    check("reset_rdata_b", ifa.rdata_b, 16'h0000);
    check("reset_valid", ifa.valid, 4'b0000);
    check("reset_count", ifa.wr_count, 8'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 2'(i), 16'((i + 1) * 16'h1111), 2'(3 - i), 2'(i));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 16'h0, 2'(i), 2'(3 - i));
      check("sweep_a", ifa.rdata_a, 32'((i + 1) * 16'h1111));
      check("sweep_b", ifa.rdata_b, 32'((4 - i) * 16'h1111));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    check("all_valid", ifa.valid, 4'b1111);
    check("count4", ifa.wr_count, 8'd4);
    drive(0, 1, 2, 16'hBEEF, 2, 2);
    check("bypass_a", ifa.rdata_a, 16'hBEEF);
    check("bypass_b", ifa.rdata_b, 16'hBEEF);
    check("nobypass_pre", ifb.rdata_a, 16'h3333);
    tick();
    drive(0, 0, 0, 0, 2, 2);
    check("nobypass_post", ifb.rdata_b, 16'hBEEF);
    tick();
    drive(1, 1, 1, 16'hAAAA, 1, 1);
    check("rst_no_bypass", ifa.rdata_a, 16'h2222);
    tick();
    drive(0, 0, 0, 0, 1, 1);
    check("rst_beats_write_reg", ifa.rdata_a, 16'h0000);
    check("rst_beats_write_valid", ifa.valid[1], 1'b0);
    check("rst_beats_write_cnt", ifa.wr_count, 8'd0);
    tick();
    for (int n = 0; n < 300; n++) begin
      drive(0, 1, 2'($urandom_range(3)), 16'($urandom), 2'($urandom_range(3)), 2'($urandom_range(3)));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 2'(i), 2'(i));
      tick();
    end
    check("saturated", ifa.wr_count, 8'd255);
    drive(0, 1, 0, 16'h1234, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("sat_hold", ifa.wr_count, 8'd255);
    check("sat_last_write", ifa.rdata_a, 16'h1234);
    tick();
    for (int n = 0; n < 500; n++) begin
      drive(($urandom_range(31) == 0), 1'($urandom), 2'($urandom), 16'($urandom), 2'($urandom), 2'($urandom));
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
